// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
package onchip_memory_arbiter_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/onchip_memory_arbiter_if.sv
// One Avalon-MM master attachment; the master modport drives requests, the slave modport answers them.
interface onchip_memory_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    localparam int BE_W = onchip_memory_arbiter_pkg::be_width(DATA_W);

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/onchip_memory_arb_grant.sv
// Purpose: picks the winning master each cycle and tracks last grant / m1 starvation.
// Latency: winner is combinational in the request cycle; state updates on the issuing edge.
// Backpressure: no issue while issue_ok is low; state holds except starve_cnt clearing on idle m1.
module onchip_memory_arb_grant
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int ARB_MODE     = ARB_RR,
    parameter int STARVE_LIMIT = 8
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    issue_ok,
    input  logic    m0_req,
    input  logic    m1_req,
    output logic    issue_vld,
    output master_e winner
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    master_e    last_grant;
    logic [7:0] starve_cnt;

    always_comb begin
        winner = M0;
        if (m0_req && m1_req) begin
            if (ARB_MODE == ARB_FIXED) begin
                winner = (starve_cnt == LIMIT) ? M1 : M0;
            end else begin
                winner = (last_grant == M0) ? M1 : M0;
            end
        end else if (m1_req) begin
            winner = M1;
        end
    end

    assign issue_vld = issue_ok & (m0_req | m1_req);

    // Starvation counts only cycles where m1 asked and the access went to m0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= M1;
            starve_cnt <= 8'd0;
        end else begin
            if (issue_vld) begin
                last_grant <= winner;
            end
            if (ARB_MODE != ARB_FIXED || !m1_req || (issue_vld && winner == M1)) begin
                starve_cnt <= 8'd0;
            end else if (issue_vld && starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Purpose: shares a single-port 1024x32 RAM between two Avalon-MM masters, one access per cycle.
// Latency: request accepted in its cycle; read data valid exactly one cycle after issue.
// Backpressure: waitrequest held high for the loser, idle masters, reset_req and until ready.
module onchip_memory_arbiter
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int ARB_MODE     = ARB_RR,
    parameter int STARVE_LIMIT = 8,
    localparam int BE_W        = be_width(DATA_W)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    reset_req,
    onchip_memory_arbiter_if.slave  m0,
    onchip_memory_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [BE_W-1:0]         mem_byteenable,
    output logic                    mem_chipselect,
    output logic                    mem_write,
    output logic [DATA_W-1:0]       mem_writedata,
    output logic                    mem_clken,
    input  logic [DATA_W-1:0]       mem_readdata
);

    logic    ready;
    logic    rdv0, rdv1;
    logic    issue_ok, issue_vld;
    logic    m0_req, m1_req, m0_rd, m1_rd;
    logic    sel_m1;
    master_e winner;

    assign issue_ok = ready & ~reset_req;
    assign m0_req   = m0.read | m0.write;
    assign m1_req   = m1.read | m1.write;
    // A simultaneous read+write is treated as a write, so it never produces read data.
    assign m0_rd    = m0.read & ~m0.write;
    assign m1_rd    = m1.read & ~m1.write;

    onchip_memory_arb_grant #(
        .ARB_MODE     (ARB_MODE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk       (clk),
        .reset_n   (reset_n),
        .issue_ok  (issue_ok),
        .m0_req    (m0_req),
        .m1_req    (m1_req),
        .issue_vld (issue_vld),
        .winner    (winner)
    );

    assign sel_m1 = issue_vld & (winner == M1);

    assign mem_address    = sel_m1 ? m1.address    : m0.address;
    assign mem_byteenable = sel_m1 ? m1.byteenable : m0.byteenable;
    assign mem_writedata  = sel_m1 ? m1.writedata  : m0.writedata;
    assign mem_chipselect = issue_vld;
    assign mem_write      = issue_vld & (sel_m1 ? m1.write : m0.write);
    assign mem_clken      = ready;

    assign m0.waitrequest = ~(issue_vld & ~sel_m1);
    assign m1.waitrequest = ~sel_m1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
            rdv0  <= 1'b0;
            rdv1  <= 1'b0;
        end else begin
            ready <= 1'b1;
            rdv0  <= issue_vld & ~sel_m1 & m0_rd;
            rdv1  <= sel_m1 & m1_rd;
        end
    end

    assign m0.readdatavalid = rdv0;
    assign m1.readdatavalid = rdv1;
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: round-robin instance on a RAM model, plus a fixed-priority instance.
module tb_onchip_memory_arbiter;
    import onchip_memory_arbiter_pkg::*;

    typedef struct {
        logic        m;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic reset_req;

    onchip_memory_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m0 ();
    onchip_memory_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m1 ();
    onchip_memory_arbiter_if #(.ADDR_W(10), .DATA_W(32)) fm0 ();
    onchip_memory_arbiter_if #(.ADDR_W(10), .DATA_W(32)) fm1 ();

    logic [9:0]  mem_address, f_mem_address;
    logic [3:0]  mem_byteenable, f_mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic        f_mem_chipselect, f_mem_write, f_mem_clken;
    logic [31:0] mem_writedata, mem_readdata, f_mem_writedata, f_mem_readdata;

    assign f_mem_readdata = 32'h0;

    onchip_memory_arbiter #(.ADDR_W(10), .DATA_W(32), .ARB_MODE(ARB_RR), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .m0(m0), .m1(m1),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    onchip_memory_arbiter #(.ADDR_W(10), .DATA_W(32), .ARB_MODE(ARB_FIXED), .STARVE_LIMIT(3)) dut_fix (
        .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .m0(fm0), .m1(fm1),
        .mem_address(f_mem_address), .mem_byteenable(f_mem_byteenable), .mem_chipselect(f_mem_chipselect),
        .mem_write(f_mem_write), .mem_writedata(f_mem_writedata), .mem_clken(f_mem_clken),
        .mem_readdata(f_mem_readdata)
    );

    function automatic logic [31:0] preload(input logic [9:0] a);
        return {16'hC0DE, 6'h00, a};
    endfunction

    // RAM model: registered address, unregistered read data, contents preloaded on the first edge.
    logic [31:0] ram [1024];
    bit   [9:0]  ram_addr_q;
    bit          ram_loaded;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= preload(10'(i));
            ram_loaded <= 1'b1;
        end else if (mem_clken && mem_chipselect) begin
            ram_addr_q <= mem_address;
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    always @(posedge clk) begin
        if (reset_n === 1'b1) begin
            assert (!(m0.read && m0.write));
            assert (!(m1.read && m1.write));
            assert (!(fm0.read && fm0.write));
            assert (!(fm1.read && fm1.write));
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem [1024];
    exp_t        sb_q [$];
    exp_t        mon_e;
    logic        exp_last;

    // Scoreboard pop: every read-data-valid must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (m0.readdatavalid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rdv_m0_unexpected: got valid data=%h, required no valid", m0.readdata);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.m !== 1'b0 || m0.readdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL rdv_m0: got master 0 data=%h, required master %0d data=%h",
                             m0.readdata, mon_e.m, mon_e.data);
                end
            end
        end
        if (m1.readdatavalid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rdv_m1_unexpected: got valid data=%h, required no valid", m1.readdata);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.m !== 1'b1 || m1.readdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL rdv_m1: got master 1 data=%h, required master %0d data=%h",
                             m1.readdata, mon_e.m, mon_e.data);
                end
            end
        end
    end

    task automatic idle_all();
        m0.read = 0;  m0.write = 0;  m0.address = '0;  m0.byteenable = '0;  m0.writedata = '0;
        m1.read = 0;  m1.write = 0;  m1.address = '0;  m1.byteenable = '0;  m1.writedata = '0;
        fm0.read = 0; fm0.write = 0; fm0.address = '0; fm0.byteenable = '0; fm0.writedata = '0;
        fm1.read = 0; fm1.write = 0; fm1.address = '0; fm1.byteenable = '0; fm1.writedata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if (m0.waitrequest !== 1'b1 || m1.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_wait: got %b/%b, required 1/1", m0.waitrequest, m1.waitrequest);
        end
        checks++;
        if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b0 ||
            m0.readdatavalid !== 1'b0 || m1.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem: got cs=%b wr=%b clken=%b rdv=%b%b, required all 0",
                     mem_chipselect, mem_write, mem_clken, m0.readdatavalid, m1.readdatavalid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m0.write = 1; m0.address = 10'h005; m0.byteenable = 4'hF; m0.writedata = 32'hDEADBEEF;
        #1;
        checks++;
        if (m0.waitrequest !== 1'b1 || m1.waitrequest !== 1'b1 || mem_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL release_first_edge: got wait=%b/%b cs=%b, required 1/1 cs=0",
                     m0.waitrequest, m1.waitrequest, mem_chipselect);
        end
        @(negedge clk); #1;
        checks++;
        if (m0.waitrequest !== 1'b0 || m1.waitrequest !== 1'b1 || mem_write !== 1'b1 ||
            mem_address !== 10'h005 || mem_writedata !== 32'hDEADBEEF || mem_clken !== 1'b1) begin
            errors++;
            $display("FAIL first_write: got wait=%b/%b wr=%b addr=%h wd=%h clken=%b, required 0/1 1 005 deadbeef 1",
                     m0.waitrequest, m1.waitrequest, mem_write, mem_address, mem_writedata, mem_clken);
        end
        ref_mem[5] = 32'hDEADBEEF;
        exp_last = 1'b0;
        @(negedge clk); idle_all();
    endtask

    task automatic test_rr_contention();
        logic win;
        logic [9:0] a;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            m0.read = 1; m0.address = 10'h010;
            m1.read = 1; m1.address = 10'h020;
            #1;
            win = ~exp_last;
            a   = win ? 10'h020 : 10'h010;
            checks++;
            if (m0.waitrequest !== win || m1.waitrequest !== ~win) begin
                errors++;
                $display("FAIL rr_grant step %0d: got wait=%b/%b, required %b/%b",
                         k, m0.waitrequest, m1.waitrequest, win, ~win);
            end
            checks++;
            if (mem_address !== a || mem_chipselect !== 1'b1 || mem_write !== 1'b0) begin
                errors++;
                $display("FAIL rr_mem step %0d: got addr=%h cs=%b wr=%b, required %h 1 0",
                         k, mem_address, mem_chipselect, mem_write, a);
            end
            sb_q.push_back('{m: win, data: ref_mem[a]});
            exp_last = win;
        end
        @(negedge clk); idle_all();
    endtask

    task automatic test_byte_write();
        @(negedge clk);
        m1.write = 1; m1.address = 10'h005; m1.byteenable = 4'b0010; m1.writedata = 32'h0000AB00;
        #1;
        checks++;
        if (m1.waitrequest !== 1'b0 || m0.waitrequest !== 1'b1 || mem_write !== 1'b1 ||
            mem_byteenable !== 4'b0010 || mem_address !== 10'h005) begin
            errors++;
            $display("FAIL byte_write: got wait=%b/%b wr=%b be=%b addr=%h, required 1/0 1 0010 005",
                     m0.waitrequest, m1.waitrequest, mem_write, mem_byteenable, mem_address);
        end
        ref_mem[5][15:8] = 8'hAB;
        exp_last = 1'b1;
        @(negedge clk);
        m1.write = 0;
        m0.read = 1; m0.address = 10'h005;
        #1;
        checks++;
        if (m0.waitrequest !== 1'b0 || mem_address !== 10'h005) begin
            errors++;
            $display("FAIL byte_readback_grant: got wait=%b addr=%h, required 0 005", m0.waitrequest, mem_address);
        end
        sb_q.push_back('{m: 1'b0, data: 32'hDEADABEF});
        exp_last = 1'b0;
        @(negedge clk); idle_all();
    endtask

    task automatic test_reset_req();
        @(negedge clk);
        m0.read = 1; m0.address = 10'h020;
        #1;
        checks++;
        if (m0.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL rreq_issue: got wait=%b, required 0", m0.waitrequest);
        end
        sb_q.push_back('{m: 1'b0, data: ref_mem[10'h020]});
        exp_last = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            reset_req = 1'b1;
            m0.read = 1; m0.address = 10'h010;
            m1.read = 1; m1.address = 10'h020;
            #1;
            if (k == 0) begin
                checks++;
                if (m0.readdatavalid !== 1'b1) begin
                    errors++;
                    $display("FAIL rreq_rdv_kept: got %b, required 1", m0.readdatavalid);
                end
            end
            checks++;
            if (m0.waitrequest !== 1'b1 || m1.waitrequest !== 1'b1 ||
                mem_chipselect !== 1'b0 || mem_clken !== 1'b1) begin
                errors++;
                $display("FAIL rreq_block step %0d: got wait=%b/%b cs=%b clken=%b, required 1/1 0 1",
                         k, m0.waitrequest, m1.waitrequest, mem_chipselect, mem_clken);
            end
        end
        @(negedge clk); reset_req = 1'b0; idle_all();
    endtask

    task automatic test_fixed_starve();
        logic win, prev_vld, prev_win;
        prev_vld = 1'b0;
        prev_win = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            fm0.read = 1; fm0.address = 10'h010;
            fm1.read = 1; fm1.address = 10'h020;
            #1;
            win = (k % 4 == 3);
            checks++;
            if (fm0.waitrequest !== win || fm1.waitrequest !== ~win || f_mem_chipselect !== 1'b1) begin
                errors++;
                $display("FAIL fixed_grant step %0d: got wait=%b/%b cs=%b, required %b/%b 1",
                         k, fm0.waitrequest, fm1.waitrequest, f_mem_chipselect, win, ~win);
            end
            checks++;
            if (fm0.readdatavalid !== (prev_vld & ~prev_win) || fm1.readdatavalid !== (prev_vld & prev_win)) begin
                errors++;
                $display("FAIL fixed_rdv step %0d: got %b/%b, required %b/%b", k,
                         fm0.readdatavalid, fm1.readdatavalid, prev_vld & ~prev_win, prev_vld & prev_win);
            end
            prev_vld = 1'b1;
            prev_win = win;
        end
        @(negedge clk); idle_all();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m0.read = 1; m0.address = 10'h030;
        #1;
        checks++;
        if (m0.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_issue: got wait=%b, required 0", m0.waitrequest);
        end
        sb_q.push_back('{m: 1'b0, data: ref_mem[10'h030]});
        @(negedge clk); idle_all();
        #1;
        checks++;
        if (m0.readdatavalid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_rdv_before: got %b, required 1", m0.readdatavalid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (m0.readdatavalid !== 1'b0 || m0.waitrequest !== 1'b1 || m1.waitrequest !== 1'b1 || mem_clken !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: got rdv=%b wait=%b/%b clken=%b, required 0 1/1 0",
                     m0.readdatavalid, m0.waitrequest, m1.waitrequest, mem_clken);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m0.read = 1; m0.address = 10'h040;
        m1.read = 1; m1.address = 10'h050;
        exp_last = 1'b1;
        #1;
        checks++;
        if (m0.waitrequest !== 1'b1 || m1.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_not_ready: got wait=%b/%b, required 1/1", m0.waitrequest, m1.waitrequest);
        end
        @(negedge clk); #1;
        checks++;
        if (m0.waitrequest !== 1'b0 || m1.waitrequest !== 1'b1 || mem_address !== 10'h040) begin
            errors++;
            $display("FAIL rstmid_first_tie: got wait=%b/%b addr=%h, required 0/1 040",
                     m0.waitrequest, m1.waitrequest, mem_address);
        end
        sb_q.push_back('{m: 1'b0, data: ref_mem[10'h040]});
        exp_last = 1'b0;
        @(negedge clk); idle_all();
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        reset_req = 1'b0;
        exp_last  = 1'b1;
        idle_all();
        for (int i = 0; i < 1024; i++) ref_mem[i] = preload(10'(i));
        test_reset();
        test_rr_contention();
        test_byte_write();
        test_reset_req();
        test_fixed_starve();
        test_reset_mid();
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d reads outstanding, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
